full_subtractor_by8: RTL and testbench

- Registered ripple-borrow subtractor for two unsigned WIDTH-bit operands plus a borrow-in.
- Produces difference D = a - b - Bin (mod 2^WIDTH) and borrow-out B.
- Used as an arithmetic leaf in datapaths; cascadable through Bin/B for wider words.

---
 rtl/fs_pkg.sv | 22 ++
 rtl/full_subtractor_bit.sv | 16 +
 rtl/full_subtractor_by8.sv | 66 ++++++
 tb/tb_full_subtractor_by8.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/fs_pkg.sv
// Shared constants and reference arithmetic for the ripple-borrow subtractor.
package fs_pkg;

  localparam int unsigned FS_DEFAULT_WIDTH = 8;
  // Widest operand fs_ref can model.
  localparam int unsigned FS_MAX_WIDTH = 32;

  // Returns {borrow, diff}: diff = a - b - bin mod 2^width, borrow = (a < b + bin).
  // The diff field is FS_MAX_WIDTH bits wide, with bits at and above width forced to zero.
  function automatic logic [FS_MAX_WIDTH:0] fs_ref(input logic [FS_MAX_WIDTH-1:0] a,
                                                   input logic [FS_MAX_WIDTH-1:0] b,
                                                   input logic                    bin,
                                                   input int unsigned             width);
    logic [FS_MAX_WIDTH:0] mask;
    logic [FS_MAX_WIDTH:0] full;
    mask = ({{FS_MAX_WIDTH{1'b0}}, 1'b1} << width) - 1'b1;
    full = ({1'b0, a} & mask) - ({1'b0, b} & mask) - {{FS_MAX_WIDTH{1'b0}}, bin};
    // A negative result sign-extends, so bit [width] is the borrow-out.
    return {full[width], full[FS_MAX_WIDTH-1:0] & mask[FS_MAX_WIDTH-1:0]};
  endfunction

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit combinational full subtractor: d = a - b - bin, bout is the borrow-out.
module full_subtractor_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference and borrow generation for a single bit position.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/full_subtractor_by8.sv
// Registered ripple-borrow subtractor: {B, D} = a - b - Bin, one cycle of latency.
module full_subtractor_by8
  import fs_pkg::*;
#(
  parameter int unsigned WIDTH = FS_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             Bin,
  output logic             out_valid,
  output logic [WIDTH-1:0] D,
  output logic             B
);

  // c[i] is the borrow into bit i; c[WIDTH] is the borrow out of the MSB.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] diff;

  assign c[0] = Bin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_subtractor_bit u_bit (
      .a    (a[i]),
      .b    (b[i]),
      .bin  (c[i]),
      .d    (diff[i]),
      .bout (c[i+1])
    );
  end

  logic [WIDTH-1:0] d_q, d_d;
  logic             b_q, b_d;
  logic             valid_q, valid_d;

  // Capture the chain result only on accepted operands; otherwise hold.
  always_comb begin
    d_d     = d_q;
    b_d     = b_q;
    valid_d = in_valid;
    if (in_valid) begin
      d_d = diff;
      b_d = c[WIDTH];
    end
  end

  // Result register with synchronous reset taking priority over in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q     <= '0;
      b_q     <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      d_q     <= d_d;
      b_q     <= b_d;
      valid_q <= valid_d;
    end
  end

  assign D         = d_q;
  assign B         = b_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_full_subtractor_by8.sv
// Directed and random checks of full_subtractor_by8 at WIDTH = 8, 1 and 16.
module tb_full_subtractor_by8;
  import fs_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic Bin;

  logic [7:0]  a8, b8, d8;
  logic [0:0]  a1, b1, d1;
  logic [15:0] a16, b16, d16;
  logic        bo8, bo1, bo16;
  logic        ov8, ov1, ov16;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  full_subtractor_by8 #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a8), .b(b8), .Bin(Bin),
    .out_valid(ov8), .D(d8), .B(bo8)
  );

  full_subtractor_by8 #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a1), .b(b1), .Bin(Bin),
    .out_valid(ov1), .D(d1), .B(bo1)
  );

  full_subtractor_by8 #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a16), .b(b16), .Bin(Bin),
    .out_valid(ov16), .D(d16), .B(bo16)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] av, input logic [15:0] bv,
                       input logic bi);
    in_valid = v;
    a16 = av;
    b16 = bv;
    a8  = av[7:0];
    b8  = bv[7:0];
    a1  = av[0:0];
    b1  = bv[0:0];
    Bin = bi;
  endtask

  task automatic check8(input string tag, input logic [7:0] ed, input logic eb,
                        input logic ev);
    check({tag, ".D"}, 64'(d8), 64'(ed));
    check({tag, ".B"}, 64'(bo8), 64'(eb));
    check({tag, ".ov"}, 64'(ov8), 64'(ev));
  endtask

  logic [FS_MAX_WIDTH:0] r8, r1, r16;
  logic [7:0]  m_d8;
  logic [0:0]  m_d1;
  logic [15:0] m_d16;
  logic        m_b8, m_b1, m_b16, m_ov;

  initial begin
    // Reset held two cycles with live operands on the inputs.
    rst = 1'b1;
    drive(1'b1, 16'h0055, 16'h0000, 1'b0);
    tick();
    check8("rst1", 8'h00, 1'b0, 1'b0);
    tick();
    check8("rst2", 8'h00, 1'b0, 1'b0);
    rst = 1'b0;

    // Back-to-back accepts.
    drive(1'b1, 16'h000F, 16'h0009, 1'b0);
    tick();
    check8("0F-09-0", 8'h06, 1'b0, 1'b1);
    drive(1'b1, 16'h000F, 16'h0009, 1'b1);
    tick();
    check8("0F-09-1", 8'h05, 1'b0, 1'b1);
    drive(1'b1, 16'h001E, 16'h0014, 1'b0);
    tick();
    check8("1E-14-0", 8'h0A, 1'b0, 1'b1);
    drive(1'b1, 16'h000F, 16'h000B, 1'b1);
    tick();
    check8("0F-0B-1", 8'h03, 1'b0, 1'b1);

    // Borrow and wrap boundaries.
    drive(1'b1, 16'h0000, 16'h0001, 1'b0);
    tick();
    check8("00-01-0", 8'hFF, 1'b1, 1'b1);
    drive(1'b1, 16'h0000, 16'h00FF, 1'b1);
    tick();
    check8("00-FF-1", 8'h00, 1'b1, 1'b1);
    drive(1'b1, 16'h0080, 16'h0080, 1'b1);
    tick();
    check8("80-80-1", 8'hFF, 1'b1, 1'b1);
    drive(1'b1, 16'h0080, 16'h0080, 1'b0);
    tick();
    check8("80-80-0", 8'h00, 1'b0, 1'b1);

    // Hold behaviour while in_valid is low and inputs keep moving.
    drive(1'b1, 16'h003C, 16'h000C, 1'b0);
    tick();
    check8("3C-0C-0", 8'h30, 1'b0, 1'b1);
    drive(1'b0, 16'h00AA, 16'h0011, 1'b1);
    tick();
    check8("hold1", 8'h30, 1'b0, 1'b0);
    drive(1'b0, 16'h0001, 16'h00F0, 1'b0);
    tick();
    check8("hold2", 8'h30, 1'b0, 1'b0);

    // Mid-stream reset wins over a simultaneous accept.
    drive(1'b1, 16'h0010, 16'h0001, 1'b0);
    tick();
    check8("10-01-0", 8'h0F, 1'b0, 1'b1);
    rst = 1'b1;
    drive(1'b1, 16'h0000, 16'h0001, 1'b0);
    tick();
    check8("rst_mid", 8'h00, 1'b0, 1'b0);
    rst = 1'b0;

    // Random regression across all three widths against the package reference.
    m_d8 = '0; m_d1 = '0; m_d16 = '0;
    m_b8 = 1'b0; m_b1 = 1'b0; m_b16 = 1'b0; m_ov = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      drive(1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom), 1'($urandom));
      if (in_valid) begin
        r8  = fs_ref(32'(a8), 32'(b8), Bin, 8);
        r1  = fs_ref(32'(a1), 32'(b1), Bin, 1);
        r16 = fs_ref(32'(a16), 32'(b16), Bin, 16);
        m_d8  = r8[7:0];   m_b8  = r8[FS_MAX_WIDTH];
        m_d1  = r1[0:0];   m_b1  = r1[FS_MAX_WIDTH];
        m_d16 = r16[15:0]; m_b16 = r16[FS_MAX_WIDTH];
      end
      m_ov = in_valid;
      tick();
      check("rnd8.D", 64'(d8), 64'(m_d8));
      check("rnd8.B", 64'(bo8), 64'(m_b8));
      check("rnd8.ov", 64'(ov8), 64'(m_ov));
      check("rnd1.D", 64'(d1), 64'(m_d1));
      check("rnd1.B", 64'(bo1), 64'(m_b1));
      check("rnd1.ov", 64'(ov1), 64'(m_ov));
      check("rnd16.D", 64'(d16), 64'(m_d16));
      check("rnd16.B", 64'(bo16), 64'(m_b16));
      check("rnd16.ov", 64'(ov16), 64'(m_ov));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
